// File: rtl/psram_ctrl.sv
// Wishbone-classic slave driving an asynchronous 16-bit PSRAM.
// Word requests are split into two half-word cycles (low half at addr, high half
// at addr+1). Each half-word cycle is held for a clock count derived from the
// access time. An ack is given only after both halves complete.
//
// state        | meaning
// -------------+----------------------------------------------------------
// INIT         | power-up wait, requests held off
// IDLE         | waiting for cyc_i & stb_i, latches the request
// ACC_LO       | half-word cycle at addr (byte lanes from sel)
// GAP          | one cycle with all strobes high between word halves
// ACC_HI       | half-word cycle at addr+1, both lanes
// ACK          | all strobes high, schedules the ack pulse
// WAIT_RELEASE | waits for stb_i low so a held strobe never re-triggers
module psram_ctrl #(
   parameter int CLK_PERIOD_NS = 20,
   parameter int T_ACCESS_NS   = 70,
   parameter int T_INIT_US     = 150
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [21:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        stb_i,
   input  logic        cyc_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   output logic        ack_o,
   output logic [31:0] data_o,
   output logic        psram_cen,
   output logic        psram_wen,
   output logic        psram_oen,
   output logic        psram_lbn,
   output logic        psram_ubn,
   output logic [21:0] psram_a,
   inout  wire  [15:0] psram_d
);

   localparam int N_RAW    = (T_ACCESS_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   localparam int N_CYC    = (N_RAW < 1) ? 1 : N_RAW;
   localparam int INIT_RAW = (T_INIT_US * 1000 + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   localparam int INIT_CYC = (INIT_RAW < 1) ? 1 : INIT_RAW;
   localparam int CW       = $clog2(N_CYC + 1);
   localparam int IW       = $clog2(INIT_CYC + 1);
   localparam logic [CW-1:0] N_LAST    = CW'(N_CYC - 1);
   localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);

   typedef enum logic [2:0] {
      INIT, IDLE, ACC_LO, GAP, ACC_HI, ACK, WAIT_RELEASE
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] init_cnt;
   logic [CW-1:0] acc_cnt;
   logic [21:0]   addr_q;
   logic [31:0]   data_q;
   logic [3:0]    sel_q;
   logic          we_q;
   logic          abort_q;
   logic          drive;
   logic [15:0]   dout;

   logic req, word, acc_last, in_access, abort_now, init_done;

   assign req       = cyc_i & stb_i;
   assign word      = |sel_q[3:2];
   assign acc_last  = (acc_cnt == '0);
   assign in_access = (state == ACC_LO) || (state == GAP) || (state == ACC_HI);
   assign abort_now = abort_q | ~req;
   assign init_done = (init_cnt == INIT_LAST);

   // Only the controller drives the data bus, and only while writing.
   assign psram_d = drive ? dout : 16'hzzzz;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= INIT;
      else        state <= state_nxt;
   end

   // Power-up wait counter; saturates once the wait has elapsed.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                  init_cnt <= '0;
      else if (state == INIT && !init_done)        init_cnt <= init_cnt + 1'b1;
   end

   // Access-time down-counter, reloaded on every state change.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                    acc_cnt <= '0;
      else if (state_nxt != state)   acc_cnt <= N_LAST;
      else if (!acc_last)            acc_cnt <= acc_cnt - 1'b1;
   end

   // Request capture in IDLE and abort tracking while a transfer is in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         abort_q <= 1'b0;
      end else if (state == IDLE) begin
         abort_q <= 1'b0;
         if (req) begin
            addr_q <= addr_i;
            data_q <= data_i;
            sel_q  <= sel_i;
            we_q   <= we_i;
         end
      end else if (in_access && !req) begin
         abort_q <= 1'b1;
      end
   end

   // Ack pulse and read data capture on the last cycle of each read half.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_o  <= 1'b0;
         data_o <= '0;
      end else begin
         ack_o <= (state == ACK);
         if (!we_q && acc_last) begin
            if (state == ACC_LO)      data_o <= {16'h0000, psram_d};
            else if (state == ACC_HI) data_o[31:16] <= psram_d;
         end
      end
   end

   // Next-state decode and PSRAM pin control.
   always_comb begin
      state_nxt = state;
      psram_cen = 1'b1;
      psram_wen = 1'b1;
      psram_oen = 1'b1;
      psram_lbn = 1'b1;
      psram_ubn = 1'b1;
      psram_a   = '0;
      drive     = 1'b0;
      dout      = '0;
      case (state)
         INIT: begin
            if (init_done) state_nxt = IDLE;
         end
         IDLE: begin
            if (req) state_nxt = ACC_LO;
         end
         ACC_LO: begin
            psram_cen = 1'b0;
            psram_a   = addr_q;
            psram_lbn = word ? 1'b0 : ~sel_q[0];
            psram_ubn = word ? 1'b0 : ~sel_q[1];
            if (we_q) begin
               psram_wen = 1'b0;
               drive     = 1'b1;
               dout      = data_q[15:0];
            end else begin
               psram_oen = 1'b0;
            end
            if (acc_last) begin
               if (abort_now)  state_nxt = IDLE;
               else if (word)  state_nxt = GAP;
               else            state_nxt = ACK;
            end
         end
         GAP: begin
            state_nxt = abort_now ? IDLE : ACC_HI;
         end
         ACC_HI: begin
            psram_cen = 1'b0;
            psram_a   = addr_q + 22'd1;
            psram_lbn = 1'b0;
            psram_ubn = 1'b0;
            if (we_q) begin
               psram_wen = 1'b0;
               drive     = 1'b1;
               dout      = data_q[31:16];
            end else begin
               psram_oen = 1'b0;
            end
            if (acc_last) state_nxt = abort_now ? IDLE : ACK;
         end
         ACK: begin
            state_nxt = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (!stb_i) state_nxt = IDLE;
         end
         default: state_nxt = INIT;
      endcase
   end

endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: behavioural PSRAM on the pins, a half-word array
// reference model for expected read data, and a queue of expected acks that a
// separate monitor checks against ack timing and data_o.
module tb_psram_ctrl;

   localparam int CLK_NS   = 20;
   localparam int N        = (70 + CLK_NS - 1) / CLK_NS;
   localparam int INIT_CYC = (150 * 1000 + CLK_NS - 1) / CLK_NS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [21:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic        ack_o;
   logic [31:0] data_o;
   logic        psram_cen, psram_wen, psram_oen, psram_lbn, psram_ubn;
   logic [21:0] psram_a;
   wire  [15:0] psram_d;

   psram_ctrl dut (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .stb_i(stb),
      .cyc_i(cyc), .sel_i(sel), .we_i(we), .ack_o(ack_o), .data_o(data_o),
      .psram_cen(psram_cen), .psram_wen(psram_wen), .psram_oen(psram_oen),
      .psram_lbn(psram_lbn), .psram_ubn(psram_ubn), .psram_a(psram_a),
      .psram_d(psram_d)
   );

   always #(CLK_NS/2) clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt++;

   int n_cmp = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // ---------------- PSRAM pin model ----------------
   logic [15:0] mem [int];
   logic [15:0] rd_val = '0;

   function automatic logic [15:0] mem_rd(input logic [21:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000;
   endfunction

   assign psram_d = (!psram_cen && !psram_oen && psram_wen) ? rd_val : 16'hzzzz;

   always @(negedge clk) begin
      logic [15:0] w;
      rd_val = mem_rd(psram_a);
      if (!psram_cen && !psram_wen) begin
         w = mem_rd(psram_a);
         if (!psram_lbn) w[7:0]  = psram_d[7:0];
         if (!psram_ubn) w[15:8] = psram_d[15:8];
         mem[int'(psram_a)] = w;
      end
   end

   // ---------------- reference model ----------------
   logic [15:0] ref_mem [int];
   logic [31:0] last_rd = '0;

   function automatic logic [15:0] ref_rd(input logic [21:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
   endfunction

   task automatic ref_wr(input logic [21:0] a, input logic [15:0] d, input logic [1:0] lanes);
      logic [15:0] w;
      w = ref_rd(a);
      if (lanes[0]) w[7:0]  = d[7:0];
      if (lanes[1]) w[15:8] = d[15:8];
      ref_mem[int'(a)] = w;
   endtask

   typedef struct { logic [31:0] data; int ack_cyc; } exp_t;
   exp_t sbq[$];

   // ---------------- monitor ----------------
   logic in_init = 1'b0;
   int   rel0 = 0;
   int   run = 0, last_end = 0;
   bit   had_run = 0;
   logic run_lbn = 1'b1, run_ubn = 1'b1;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (ack_o) begin
            if (sbq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_ack at cycle %0d", cyc_cnt);
            end else begin
               e = sbq.pop_front();
               check("ack_cycle", 32'(cyc_cnt), 32'(e.ack_cyc));
               check("data_o", data_o, e.data);
            end
            had_run = 0;
         end
         if (in_init && (cyc_cnt - rel0) <= INIT_CYC)
            check("init_strobes", {27'd0, psram_cen, psram_wen, psram_oen, psram_lbn, psram_ubn}, 32'h1F);
         if (!psram_oen || !psram_wen)
            check("strobe_needs_cen", {31'd0, psram_cen}, 32'd0);
         if (!psram_cen)
            check("oen_wen_exclusive", {31'd0, psram_oen ^ psram_wen}, 32'd1);
         if (!psram_cen) begin
            if (run == 0) begin
               if (had_run) check("half_gap", 32'(cyc_cnt - last_end), 32'd1);
               run_lbn = psram_lbn;
               run_ubn = psram_ubn;
            end
            run++;
         end else if (run > 0) begin
            check("half_len", 32'(run), 32'(N));
            run = 0;
            last_end = cyc_cnt;
            had_run = 1;
         end
      end
   end

   // ---------------- master ----------------
   task automatic do_req(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, input int extra, input int force_ack);
      logic [21:0] a1;
      bit          word;
      exp_t        e;
      bit          seen;
      a1   = a + 22'd1;
      word = (s[3:2] != 2'b00);
      if (w) begin
         ref_wr(a, d[15:0], word ? 2'b11 : s[1:0]);
         if (word) ref_wr(a1, d[31:16], 2'b11);
         e.data = last_rd;
      end else begin
         e.data  = word ? {ref_rd(a1), ref_rd(a)} : {16'h0000, ref_rd(a)};
         last_rd = e.data;
      end
      @(negedge clk);
      addr = a; wdata = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
      e.ack_cyc = (force_ack >= 0) ? force_ack : (cyc_cnt + 1 + (word ? 2*N + 2 : N + 1));
      sbq.push_back(e);
      seen = 0;
      for (int i = 0; i < INIT_CYC + 200; i++) begin
         @(negedge clk);
         if (ack_o) begin seen = 1; break; end
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL ack_timeout addr 0x%06h: no ack, expected one", a);
      end
      repeat (extra) @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      logic [21:0] a;
      logic [3:0]  sels [4];
      sels[0] = 4'b0001; sels[1] = 4'b0010; sels[2] = 4'b0011; sels[3] = 4'b1111;

      repeat (3) @(negedge clk);
      check("rst_ack", {31'd0, ack_o}, 32'd0);
      check("rst_data_o", data_o, 32'd0);
      check("rst_strobes", {27'd0, psram_cen, psram_wen, psram_oen, psram_lbn, psram_ubn}, 32'h1F);
      check("rst_addr", {10'd0, psram_a}, 32'd0);

      rst = 1'b1;
      rel0 = cyc_cnt;
      in_init = 1'b1;
      repeat (5) @(negedge clk);
      // issued during INIT: acked exactly N+1 cycles after the first IDLE edge
      do_req(22'h0, 32'h0, 4'b0011, 1'b0, 0, rel0 + INIT_CYC + N + 2);
      in_init = 1'b0;

      do_req(22'h000010, 32'hDEADBEEF, 4'b1111, 1'b1, 0, -1);
      check("mem_0x10", {16'h0, mem_rd(22'h10)}, 32'h0000BEEF);
      check("mem_0x11", {16'h0, mem_rd(22'h11)}, 32'h0000DEAD);

      do_req(22'h000010, 32'h0, 4'b1111, 1'b0, 1, -1);
      do_req(22'h000010, 32'h0, 4'b0011, 1'b0, 0, -1);

      do_req(22'h000011, 32'h0000AB00, 4'b0010, 1'b1, 0, -1);
      check("byte_lanes", {30'd0, run_ubn, run_lbn}, 32'b01);
      do_req(22'h000010, 32'h0, 4'b1111, 1'b0, 0, -1);

      d = $urandom;
      do_req(22'h3FFFFF, d, 4'b1111, 1'b1, 3, -1);
      check("wrap_lo", {16'h0, mem_rd(22'h3FFFFF)}, {16'h0, d[15:0]});
      check("wrap_hi", {16'h0, mem_rd(22'h000000)}, {16'h0, d[31:16]});

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) a = 22'h3FFFF0 + 22'($urandom_range(0, 15));
         else                           a = 22'($urandom_range(0, 31));
         do_req(a, $urandom, sels[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), -1);
      end

      repeat (6) @(negedge clk);
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/psram_ctrl.md
Name: psram_ctrl

Overview:
- Wishbone-classic slave that maps 16/32-bit bus requests onto an external asynchronous 16-bit PSRAM with a 22-bit half-word address.
- Sits behind the RAM bus wrapper, which converts byte accesses into half-word lanes before they reach this block.
- Word accesses are split into two sequential half-word cycles, timed by counters derived from the clock period.

Parameters:
- CLK_PERIOD_NS, 20, clk_i period in ns.
- T_ACCESS_NS, 70, PSRAM read/write cycle time in ns. Cycles per access: N = ceil(T_ACCESS_NS / CLK_PERIOD_NS), minimum 1. N = 4 at the defaults.
- T_INIT_US, 150, power-up wait in µs before the first access is accepted.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset (asserted when 0).
- addr_i  in  22  half-word address.
- data_i  in  32  write data. Low half goes to addr, high half to addr+1.
- stb_i  in  1  Wishbone strobe.
- cyc_i  in  1  Wishbone cycle.
- sel_i  in  4  lane select: 0001 = low byte, 0010 = high byte, 0011 = half-word, 1111 = word.
- we_i  in  1  1 = write.
- ack_o  out  1  one-cycle transfer acknowledge.
- data_o  out  32  read data.
- psram_cen  out  1  chip enable, active low.
- psram_wen  out  1  write enable, active low.
- psram_oen  out  1  output enable, active low.
- psram_lbn  out  1  lower byte enable, active low.
- psram_ubn  out  1  upper byte enable, active low.
- psram_a  out  22  PSRAM address.
- psram_d  inout  16  PSRAM data, tri-stated unless writing.

Behaviour:
- Reset (rst_i = 0, asynchronous): state = INIT.
  - psram_cen, psram_wen, psram_oen, psram_lbn, psram_ubn = 1.
  - psram_a = 0; psram_d = Z; ack_o = 0; data_o = 0.
  - Init counter cleared.
- States: INIT, IDLE, ACC_LO, GAP, ACC_HI, ACK, WAIT_RELEASE.
- INIT: count ceil(T_INIT_US*1000 / CLK_PERIOD_NS) cycles, then go to IDLE. Requests arriving during INIT are held off (no ack) until IDLE.
- IDLE: when cyc_i & stb_i are sampled high, latch addr_i, data_i, sel_i, we_i and go to ACC_LO.
- ACC_LO (N cycles):
  - psram_a = addr; psram_cen = 0.
  - psram_lbn = ~sel[0], psram_ubn = ~sel[1], except a word access (sel[3:2] != 0) uses both bytes.
  - Read: psram_oen = 0; the last cycle latches psram_d into data_o[15:0] and clears data_o[31:16].
  - Write: psram_wen = 0; psram_d = data[15:0].
- After ACC_LO: word access (sel[3:2] != 0) goes to GAP; otherwise to ACK.
- GAP (1 cycle): all strobes high, psram_d = Z.
- ACC_HI (N cycles): psram_a = addr + 1, wrapping 0x3FFFFF -> 0x000000. Both bytes enabled. Read latches data_o[31:16]; write drives data[31:16].
- ACK: all strobes high, psram_d = Z, ack_o = 1 for exactly one cycle, then WAIT_RELEASE.
- WAIT_RELEASE: stay until stb_i = 0, then IDLE. A held strobe never re-triggers a transfer.
- Latency from the request edge to ack_o high:
  - half-word or byte: N + 1 cycles (5 at the defaults);
  - word: 2N + 2 cycles (10 at the defaults).
- Byte reads return the full 16-bit half-word; the wrapper selects the lane.
- Byte writes touch only the enabled byte; the disabled byte in PSRAM is unchanged.
- data_o holds its last read value until the next read completes. Writes do not modify data_o.
- cyc_i or stb_i dropping mid-access: finish the current PSRAM half-cycle (it cannot be aborted), skip any remaining half, suppress ack_o, return to IDLE.
- Outside active write cycles, psram_d is never driven.

Test Plan:
- Reset, then deassert; model the PSRAM and wait for INIT to finish. Strobes stay high and psram_d = Z throughout; a request issued during INIT is acked only after INIT completes.
- Word write addr = 0x000010, data = 0xDEADBEEF, sel = 1111:
  - 0xBEEF goes to 0x10 and 0xDEAD to 0x11, each with psram_wen low for 4 cycles;
  - a 1-cycle gap separates the two halves;
  - ack_o pulses once, 10 cycles after the request.
- Word read of the same address -> data_o = 0xDEADBEEF at ack.
- Half-word read addr 0x10, sel = 0011 -> data_o = 0x0000BEEF; ack 5 cycles after the request.
- Byte write addr 0x11, data = 0x0000AB00, sel = 0010:
  - psram_ubn = 0, psram_lbn = 1;
  - the following word read of 0x10 returns 0xABADBEEF.
- Word write at 0x3FFFFF -> the second half is written at 0x000000. Holding stb_i high for 3 extra cycles after ack produces no second transfer.
